// File: rtl/mode_tracker.sv
// Tracks the number with the highest reported running count, emits leader-change
// events through a 2-entry FIFO, and raises sticky threshold and overflow flags.
module mode_tracker #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             I_VALID,
   input  logic [7:0]       I_NUM,
   input  logic [CNT_W-1:0] I_CNT,
   input  logic             I_CLR,
   input  logic [CNT_W-1:0] I_THR,
   input  logic             I_EVT_READY,
   output logic             O_MODE_VLD,
   output logic [7:0]       O_MODE_NUM,
   output logic [CNT_W-1:0] O_MODE_CNT,
   output logic             O_EVT_VALID,
   output logic [7:0]       O_EVT_NUM,
   output logic [CNT_W-1:0] O_EVT_CNT,
   output logic             O_ALARM,
   output logic             O_OVF
);

   localparam int unsigned NUM_W   = 8;
   localparam int unsigned OCC_W   = 2;
   localparam int unsigned FIFO_DP = 2;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_TRACK = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_W-1:0]   mode_num_q, mode_num_d;
   logic [CNT_W-1:0]   mode_cnt_q, mode_cnt_d;

   logic [NUM_W-1:0]   e0_num_q, e0_num_d;
   logic [CNT_W-1:0]   e0_cnt_q, e0_cnt_d;
   logic [NUM_W-1:0]   e1_num_q, e1_num_d;
   logic [CNT_W-1:0]   e1_cnt_q, e1_cnt_d;
   logic [OCC_W-1:0]   occ_q, occ_d;

   logic               alarm_q, alarm_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic [OCC_W-1:0]   occ_after_pop;

   assign accept    = I_VALID & ~I_CLR;
   assign pop       = (occ_q != OCC_W'(0)) & I_EVT_READY;
   assign fifo_full = (occ_q == OCC_W'(FIFO_DP));

   // Leader FSM: strict greater-than takeover keeps the incumbent on ties
   always_comb begin
      state_d    = state_q;
      mode_num_d = mode_num_q;
      mode_cnt_d = mode_cnt_q;
      push       = 1'b0;
      if (I_CLR) begin
         state_d    = S_EMPTY;
         mode_num_d = '0;
         mode_cnt_d = '0;
      end else if (accept) begin
         case (state_q)
            S_EMPTY: begin
               state_d    = S_TRACK;
               mode_num_d = I_NUM;
               mode_cnt_d = I_CNT;
               push       = 1'b1;
            end
            S_TRACK: begin
               if (I_NUM == mode_num_q) begin
                  mode_cnt_d = I_CNT;
               end else if (I_CNT > mode_cnt_q) begin
                  mode_num_d = I_NUM;
                  mode_cnt_d = I_CNT;
                  push       = 1'b1;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Event FIFO: pop shifts first, then the push lands in the first free slot
   always_comb begin
      e0_num_d      = e0_num_q;
      e0_cnt_d      = e0_cnt_q;
      e1_num_d      = e1_num_q;
      e1_cnt_d      = e1_cnt_q;
      occ_d         = occ_q;
      occ_after_pop = occ_q;
      if (I_CLR) begin
         e0_num_d = '0;
         e0_cnt_d = '0;
         e1_num_d = '0;
         e1_cnt_d = '0;
         occ_d    = '0;
      end else begin
         if (pop) begin
            e0_num_d      = e1_num_q;
            e0_cnt_d      = e1_cnt_q;
            e1_num_d      = '0;
            e1_cnt_d      = '0;
            occ_after_pop = occ_q - OCC_W'(1);
         end
         occ_d = occ_after_pop;
         if (push && (occ_after_pop != OCC_W'(FIFO_DP))) begin
            if (occ_after_pop == OCC_W'(0)) begin
               e0_num_d = mode_num_d;
               e0_cnt_d = mode_cnt_d;
            end else begin
               e1_num_d = mode_num_d;
               e1_cnt_d = mode_cnt_d;
            end
            occ_d = occ_after_pop + OCC_W'(1);
         end
      end
   end

   // Sticky flags; alarm looks at the registered leader so it trails it by one edge
   always_comb begin
      alarm_d = alarm_q;
      ovf_d   = ovf_q;
      if (I_CLR) begin
         alarm_d = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         if ((state_q == S_TRACK) && (I_THR != '0) && (mode_cnt_q >= I_THR)) begin
            alarm_d = 1'b1;
         end
         if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         mode_num_q <= '0;
         mode_cnt_q <= '0;
         e0_num_q   <= '0;
         e0_cnt_q   <= '0;
         e1_num_q   <= '0;
         e1_cnt_q   <= '0;
         occ_q      <= '0;
         alarm_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_num_q <= mode_num_d;
         mode_cnt_q <= mode_cnt_d;
         e0_num_q   <= e0_num_d;
         e0_cnt_q   <= e0_cnt_d;
         e1_num_q   <= e1_num_d;
         e1_cnt_q   <= e1_cnt_d;
         occ_q      <= occ_d;
         alarm_q    <= alarm_d;
         ovf_q      <= ovf_d;
      end
   end

   assign O_MODE_VLD  = (state_q == S_TRACK);
   assign O_MODE_NUM  = mode_num_q;
   assign O_MODE_CNT  = mode_cnt_q;
   assign O_EVT_VALID = (occ_q != OCC_W'(0));
   assign O_EVT_NUM   = e0_num_q;
   assign O_EVT_CNT   = e0_cnt_q;
   assign O_ALARM     = alarm_q;
   assign O_OVF       = ovf_q;

endmodule

// File: doc/mode_tracker.md
MODE_TRACKER -- requirements
Module: mode_tracker

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: CNT_W, default 8, width of the count input and all count outputs.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 I_VALID  in  1  the sample on I_NUM/I_CNT is valid this cycle.
REQ-006 I_NUM  in  8  number whose running count is being reported.
REQ-007 I_CNT  in  CNT_W  current running count of I_NUM; it can wrap to 0 after all-ones.
REQ-008 I_CLR  in  1  synchronous clear of all tracking state.
REQ-009 I_THR  in  CNT_W  alarm threshold; 0 disables the alarm.
REQ-010 I_EVT_READY  in  1  the consumer accepts the head event.
REQ-011 O_MODE_VLD  out  1  a leader exists.
REQ-012 O_MODE_NUM  out  8  current leader number.
REQ-013 O_MODE_CNT  out  CNT_W  current leader count.
REQ-014 O_EVT_VALID  out  1  the head of the event FIFO is valid.
REQ-015 O_EVT_NUM / O_EVT_CNT  out  8 / CNT_W  head event: the new leader and its count.
REQ-016 O_ALARM  out  1  sticky flag: leader count reached the threshold.
REQ-017 O_OVF  out  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-018 Leader FSM states SHALL be EMPTY (O_MODE_VLD=0) and TRACK (O_MODE_VLD=1).
REQ-019 EMPTY, accepted sample: leader := (I_NUM, I_CNT); go to TRACK; push an event.
REQ-020 TRACK, accepted sample with I_NUM == leader: O_MODE_CNT := I_CNT, even if it is lower (wrap); no event.
REQ-021 TRACK, I_NUM != leader and I_CNT > O_MODE_CNT (unsigned): leader := (I_NUM, I_CNT); push an event.
REQ-022 TRACK, I_NUM != leader and I_CNT <= O_MODE_CNT: no change. On a tie the incumbent SHALL be kept.
REQ-023 A sample is accepted when I_VALID=1 and I_CLR=0.
REQ-024 Latency: mode outputs SHALL update on the edge that samples the input (visible cycle N+1).
REQ-025 A pushed event SHALL appear on O_EVT_VALID at N+1 if the FIFO was empty.
REQ-026 The event FIFO SHALL be 2 entries deep, first-in first-out.
REQ-027 A pop SHALL occur on any edge where O_EVT_VALID=1 and I_EVT_READY=1.
REQ-028 While O_EVT_VALID=1 and I_EVT_READY=0, O_EVT_NUM and O_EVT_CNT SHALL hold stable.
REQ-029 Push when full without a same-cycle pop: the new event is dropped and O_OVF set; stored entries are unchanged.
REQ-030 Push when full with a same-cycle pop: the new event is stored and O_OVF is not set.
REQ-031 Push and pop on a 1-entry FIFO: the occupancy stays 1 and the head advances to the new event.
REQ-032 O_ALARM SHALL be set on the edge after the leader count becomes >= I_THR, with I_THR != 0 and state TRACK.
REQ-033 O_ALARM SHALL stay set until I_CLR or rst, including after a later wrap or a leader change.
REQ-034 I_CLR SHALL take priority over I_VALID; the sample in that cycle is discarded.
REQ-035 I_CLR SHALL return the FSM to EMPTY, flush the FIFO, and clear O_ALARM and O_OVF.
REQ-036 I_CLR SHALL have no effect on I_THR, which is sampled live every cycle.
REQ-037 Counts SHALL never be incremented internally; all arithmetic is unsigned CNT_W-bit comparison only.

Reset
REQ-038 rst=1 SHALL set state EMPTY, O_MODE_VLD=0, O_MODE_NUM=0, O_MODE_CNT=0, O_EVT_VALID=0, O_EVT_NUM=0, O_EVT_CNT=0, O_ALARM=0, O_OVF=0, FIFO empty.
REQ-039 rst SHALL override I_CLR and I_VALID, including mid-handshake; a pending event is lost.

Verification
REQ-040 After reset, (5,1) then (5,2), READY=1 -> mode (5,1) then (5,2); a single event (5,1) at cycle 1; no further event.
REQ-041 From leader (5,3): (9,3) then (9,4) -> the tie keeps 5; then leader 9, count 4; event (9,4).
REQ-042 READY=0, three leader changes (1,1),(2,2),(3,3) -> FIFO holds (1,1),(2,2); O_OVF=1; on release they pop in order and (3,3) is never seen.
REQ-043 I_THR=4, leader 7 counts 3,4 -> O_ALARM rises the cycle after 4; leader 7 with count 255 then 0 -> leader stays 7 with count 0 and O_ALARM stays 1.
REQ-044 I_CLR and I_VALID (8,9) in the same cycle with the FIFO full -> EMPTY, O_EVT_VALID=0, alarm and overflow cleared, (8,9) ignored.
REQ-045 rst asserted while O_EVT_VALID=1 and READY=0 -> all outputs 0 on the next cycle.
